sig_stable_filter: RTL



---
 rtl/sig_path_pkg.sv | 21 ++
 rtl/sig_stable_filter_sat_counter.sv | 24 ++
 rtl/sig_stable_filter.sv | 89 ++++++++
 3 files changed

// File: rtl/sig_path_pkg.sv
// Shared definitions for the signal-path blocks.
// Holds the stability-filter state encoding, the default widths used along
// the delay-line path, and the width derivation for the stability counter.
package sig_path_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int NBITS_DEF         = 2;
    localparam int GLITCH_W_DEF      = 8;
    localparam int STABLE_CYCLES_DEF = 4;

    // Wide enough to hold every count from 0 up to and including stable_cycles.
    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/sig_stable_filter_sat_counter.sv
// sat_counter: saturating up-counter with synchronous active-low clear.
// Ports:
//   clk    - clock, posedge
//   clr_n  - synchronous clear, active low (wins over inc)
//   inc    - increment enable; ignored once the count is all-ones
//   count  - registered count value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sig_stable_filter.sv
// sig_stable_filter: publishes a bus value only after it has been sampled
// unchanged on STABLE_CYCLES consecutive clock edges.
// Ports:
//   clk            - clock, posedge
//   rst_n          - synchronous reset, active low
//   SIG_IN         - delayed bus from the delay line (Nbits+1 wide)
//   Stable_sig_out - last qualified value
//   stable_valid   - set once any value has qualified
//   change_pulse   - one-cycle strobe on each Stable_sig_out update
//   glitch_cnt     - saturating count of candidates abandoned before qualifying
module sig_stable_filter
    import sig_path_pkg::*;
#(
    parameter int Nbits         = NBITS_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int GLITCH_W      = GLITCH_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [Nbits:0]      SIG_IN,
    output logic [Nbits:0]      Stable_sig_out,
    output logic                stable_valid,
    output logic                change_pulse,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int CNT_W = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [Nbits:0]   cand;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    state_t           state;

    logic match;
    logic is_new;
    logic qualify;
    logic glitch;

    always_comb begin
        match    = (SIG_IN == cand);
        cnt_next = 1;
        if (match) begin
            cnt_next = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
        end
        // Re-qualifying the value already on the output is not an update.
        is_new  = !stable_valid || (SIG_IN != Stable_sig_out);
        qualify = (cnt_next == CNT_MAX) && is_new;
        // A candidate counts as a glitch only if it was a real (different)
        // pending value that got dropped before reaching full count.
        glitch  = !match && (cnt != '0) && (cnt < CNT_MAX) &&
                  (!stable_valid || (cand != Stable_sig_out));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand           <= '0;
            cnt            <= '0;
            Stable_sig_out <= '0;
            stable_valid   <= 1'b0;
            change_pulse   <= 1'b0;
            state          <= IDLE;
        end else begin
            cand         <= SIG_IN;
            cnt          <= cnt_next;
            change_pulse <= qualify;
            if (qualify) begin
                Stable_sig_out <= SIG_IN;
                stable_valid   <= 1'b1;
            end
            case (state)
                IDLE:  if (qualify) state <= HOLD;
                HOLD:  if (!qualify && (SIG_IN != Stable_sig_out)) state <= TRACK;
                TRACK: if (qualify || (SIG_IN == Stable_sig_out)) state <= HOLD;
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(
        .W(GLITCH_W)
    ) u_glitch_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (glitch),
        .count (glitch_cnt)
    );

endmodule
